// File: rtl/direct_mapped_cache.sv
// Direct-mapped 1 KiB cache store: 64 lines x 4 words x 32 b with per-line
// tag, valid and dirty. Lookup is combinational; refill, CPU write and
// invalidation update state on the rising clock edge.
module direct_mapped_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        store,
  input  logic        edit,
  input  logic        invalid,
  input  logic [31:0] din,
  output logic        hit,
  output logic [31:0] dout,
  output logic        valid,
  output logic        dirty,
  output logic [21:0] tag
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 22;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned WORD_W = 2;
  localparam int unsigned LINES  = 64;
  localparam int unsigned WORDS  = 4;

  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] word;

  logic [WORDS-1:0][DATA_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]             tag_q  [LINES];
  logic [LINES-1:0]             valid_q;
  logic [LINES-1:0]             dirty_q;

  // Byte offset is irrelevant for word-only accesses.
  logic unused_byte_offset;
  assign unused_byte_offset = ^addr[1:0];

  assign addr_tag = addr[31:10];
  assign idx      = addr[9:4];
  assign word     = addr[3:2];

  // Zero-latency lookup of the indexed line (no write bypass).
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign dout  = data_q[idx][word];
  assign hit   = valid_q[idx] && (tag_q[idx] == addr_tag);

  // State update, priority rst > invalid > store > edit; edit hit uses pre-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (invalid) begin
      valid_q[idx] <= 1'b0;
      dirty_q[idx] <= 1'b0;
    end else if (store) begin
      data_q[idx][word] <= din;
      tag_q[idx]        <= addr_tag;
      valid_q[idx]      <= 1'b1;
      dirty_q[idx]      <= 1'b0;
    end else if (edit && hit) begin
      data_q[idx][word] <= din;
      dirty_q[idx]      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Scoreboard bench for direct_mapped_cache: stimulus pushes expected lookup
// results, a monitor samples the outputs mid-cycle and compares.
module tb_direct_mapped_cache;

  typedef struct packed {
    logic        hit;
    logic [31:0] dout;
    logic        valid;
    logic        dirty;
    logic [21:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        store = 1'b0;
  logic        edit = 1'b0;
  logic        invalid = 1'b0;
  logic [31:0] din = '0;
  logic        hit;
  logic [31:0] dout;
  logic        valid;
  logic        dirty;
  logic [21:0] tag;

  logic  chk = 1'b0;
  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;

  direct_mapped_cache dut (
    .clk(clk), .rst(rst), .addr(addr), .store(store), .edit(edit),
    .invalid(invalid), .din(din), .hit(hit), .dout(dout), .valid(valid),
    .dirty(dirty), .tag(tag)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic h, input logic [31:0] d, input logic v,
                              input logic dy, input logic [21:0] t);
    exp_t e;
    e.hit = h; e.dout = d; e.valid = v; e.dirty = dy; e.tag = t;
    return e;
  endfunction

  // One stimulus cycle, driven on the falling edge; optionally expects a lookup result.
  task automatic cyc(input logic r, input logic s, input logic e, input logic inv,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic c, input string nm, input exp_t ex);
    @(negedge clk);
    rst = r; store = s; edit = e; invalid = inv; addr = a; din = d; chk = c;
    if (c) begin
      exp_q.push_back(ex);
      name_q.push_back(nm);
    end
  endtask

  task automatic rd(input logic [31:0] a, input string nm, input exp_t ex);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, a, 32'h0, 1'b1, nm, ex);
  endtask

  task automatic op(input logic s, input logic e, input logic inv,
                    input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, s, e, inv, a, d, 1'b0, "", '0);
  endtask

  // Monitor: sample outputs 2 time units after the falling edge.
  always begin
    exp_t got;
    exp_t ex;
    string nm;
    @(negedge clk);
    #2;
    if (chk) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL no_expectation: lookup at addr=%h with empty scoreboard", addr);
      end else begin
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        got = mk(hit, dout, valid, dirty, tag);
        if (got !== ex) begin
          bad++;
          $display("FAIL %s: got hit=%0b dout=%h valid=%0b dirty=%0b tag=%h, expected hit=%0b dout=%h valid=%0b dirty=%0b tag=%h",
                   nm, got.hit, got.dout, got.valid, got.dirty, got.tag,
                   ex.hit, ex.dout, ex.valid, ex.dirty, ex.tag);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    // Reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "", '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "", '0);
    rd(32'h0000_0000, "reset_addr0", mk(1'b0, 32'h0, 1'b0, 1'b0, 22'h0));
    rd(32'hFFFF_FFFC, "reset_addr_max", mk(1'b0, 32'h0, 1'b0, 1'b0, 22'h0));

    // Refill words
    op(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h1111_1111);
    op(1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h1111_1111);
    op(1'b1, 1'b0, 1'b0, 32'h0000_00A8, 32'h1111_1111);
    op(1'b1, 1'b0, 1'b0, 32'h0000_001C, 32'h1111_1111);
    rd(32'h0000_0000, "refill_hit_0x00", mk(1'b1, 32'h1111_1111, 1'b1, 1'b0, 22'h0));
    rd(32'h0000_00A8, "refill_hit_0xA8", mk(1'b1, 32'h1111_1111, 1'b1, 1'b0, 22'h0));
    rd(32'h0000_0008, "unfilled_word_0x08", mk(1'b1, 32'h0, 1'b1, 1'b0, 22'h0));
    rd(32'h0000_00B4, "empty_line_0xB4", mk(1'b0, 32'h0, 1'b0, 1'b0, 22'h0));
    rd(32'h0000_0400, "tag_mismatch_0x400", mk(1'b0, 32'h1111_1111, 1'b1, 1'b0, 22'h0));

    // Write hit
    op(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h2222_2222);
    rd(32'h0000_0008, "edit_hit_0x08", mk(1'b1, 32'h2222_2222, 1'b1, 1'b1, 22'h0));
    rd(32'h0000_0000, "edit_neighbour_0x00", mk(1'b1, 32'h1111_1111, 1'b1, 1'b1, 22'h0));
    rd(32'h0000_0004, "edit_neighbour_0x04", mk(1'b1, 32'h1111_1111, 1'b1, 1'b1, 22'h0));

    // Edit misses change nothing
    op(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF);
    rd(32'h0000_0400, "edit_tag_miss", mk(1'b0, 32'h1111_1111, 1'b1, 1'b1, 22'h0));
    op(1'b0, 1'b1, 1'b0, 32'h0000_00B4, 32'h3333_3333);
    rd(32'h0000_00B4, "edit_empty_miss", mk(1'b0, 32'h0, 1'b0, 1'b0, 22'h0));

    // store + edit together: store wins, dirty stays clear
    op(1'b1, 1'b1, 1'b0, 32'h0000_001C, 32'h4444_4444);
    rd(32'h0000_001C, "store_over_edit", mk(1'b1, 32'h4444_4444, 1'b1, 1'b0, 22'h0));
    rd(32'h0000_001F, "byte_offset_ignored", mk(1'b1, 32'h4444_4444, 1'b1, 1'b0, 22'h0));

    // invalid + store together: invalid wins, data untouched
    op(1'b1, 1'b0, 1'b1, 32'h0000_00A8, 32'h9999_9999);
    rd(32'h0000_00A8, "invalid_over_store", mk(1'b0, 32'h1111_1111, 1'b0, 1'b0, 22'h0));

    // Refill with a different tag overwrites the tag
    op(1'b1, 1'b0, 1'b0, 32'h0000_04A0, 32'h5555_5555);
    rd(32'h0000_04A0, "new_tag_hit", mk(1'b1, 32'h5555_5555, 1'b1, 1'b0, 22'h1));
    rd(32'h0000_00A8, "old_tag_miss", mk(1'b0, 32'h1111_1111, 1'b1, 1'b0, 22'h1));

    // Read during a store cycle shows pre-edge contents, then the new word
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_002C, 32'h7777_7777, 1'b1, "store_cycle_old_data",
        mk(1'b0, 32'h0, 1'b0, 1'b0, 22'h0));
    rd(32'h0000_002C, "store_after_edge", mk(1'b1, 32'h7777_7777, 1'b1, 1'b0, 22'h0));

    // Invalidate line 0
    op(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0);
    rd(32'h0000_0000, "invalidated_0x00", mk(1'b0, 32'h1111_1111, 1'b0, 1'b0, 22'h0));
    rd(32'h0000_0008, "invalidated_0x08", mk(1'b0, 32'h2222_2222, 1'b0, 1'b0, 22'h0));

    // Reset mid-refill discards everything
    op(1'b1, 1'b0, 1'b0, 32'h0000_0800, 32'h6666_6666);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0804, 32'h6666_6666, 1'b0, "", '0);
    rd(32'h0000_0800, "midreset_0x800", mk(1'b0, 32'h0, 1'b0, 1'b0, 22'h0));
    rd(32'h0000_001C, "midreset_0x1C", mk(1'b0, 32'h0, 1'b0, 1'b0, 22'h0));
    rd(32'h0000_04A0, "midreset_0x4A0", mk(1'b0, 32'h0, 1'b0, 1'b0, 22'h0));

    // Idle and drain the scoreboard (bounded)
    op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/direct_mapped_cache.md
# direct_mapped_cache

Direct-mapped, single-port, 1 KiB cache data/tag store: 64 lines × 4 words × 32 bits, with per-line valid and dirty bits. It holds the storage and hit-detection half of a cache. An external cache controller drives it:
- line refill through `store`
- CPU write hits through `edit`
- line invalidation through `invalid`
- lookup through the combinational `hit`/`dout`/`valid`/`dirty`/`tag` outputs, including victim inspection before write-back

## Interface
Parameters (fixed, not overridable): none exposed. Geometry is hard-wired.
- Address split:
  - tag = addr[31:10] (22 b)
  - index = addr[9:4] (64 lines)
  - word = addr[3:2] (4 words/line)
  - addr[1:0] ignored (word access only)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- addr  in  32  byte address of access
- store  in  1  refill write: write din into addressed word, load tag, set valid, clear dirty
- edit  in  1  CPU write: on hit, write din into addressed word, set dirty
- invalid  in  1  clear valid and dirty of addressed line
- din  in  32  write data
- hit  out  1  valid[index] && tag[index] == addr[31:10]
- dout  out  32  data word at (index, word), regardless of hit
- valid  out  1  valid bit of indexed line
- dirty  out  1  dirty bit of indexed line
- tag  out  22  stored tag of indexed line, used by the controller to form the write-back address

## Operation
- Storage:
  - data[64][4] × 32 b
  - tag[64] × 22 b
  - valid[64]
  - dirty[64]
- Outputs are purely combinational from addr and current state; no output registers.
- Per rising clk edge, priority rst > invalid > store > edit. Only one action is taken per cycle.
- rst=1: all valid ← 0, all dirty ← 0, all tags ← 0, all data words ← 0.
- invalid=1: valid[index] ← 0, dirty[index] ← 0. Tag and data are unchanged.
- store=1:
  - data[index][word] ← din; tag[index] ← addr[31:10]; valid[index] ← 1; dirty[index] ← 0.
  - Unconditional: overwrites any previous tag. Refilling a full line takes 4 store cycles, one per word.
- edit=1:
  - Only if hit: data[index][word] ← din, dirty[index] ← 1.
  - On miss, no state changes; the controller must refill first.
- No control asserted: state holds. Reads are non-destructive.
- Other words in the line are never modified by a single-word write.

## Timing
- Read latency 0 cycles. hit/dout/valid/dirty/tag settle combinationally after addr changes.
- Write effect is visible on outputs immediately after the rising edge that samples the control.
- Same-cycle read of the written word returns old data before the edge and new data after it. There is no write-through bypass.
- Reset value of outputs after rst: hit=0, dout=0, valid=0, dirty=0, tag=0 for every addr.
- edit hit is evaluated on pre-edge state. edit and store asserted together: store wins, and dirty ends 0.
- Reset asserted mid-sequence (e.g. between refill words) discards all lines. No partial state survives.
- Stimulus convention: change inputs on the falling edge so they are stable at the rising edge.

## Test plan
- Reset, then read addr 0x0000_0000 -> hit=0, valid=0, dirty=0, tag=0, dout=0.
- Refill via store: store with din=0x1111_1111 at addr 0x00, 0x04, 0xA8, 0x1C, one cycle each, then drop store.
  - Read 0x00 -> hit=1, dout=0x1111_1111, dirty=0, tag=0.
  - Read 0xA8 -> hit=1 (line 10, word 2).
- Miss on empty line: read 0xB4 (line 11) -> hit=0, valid=0.
- Miss on tag mismatch: read 0x400 (line 0, tag 1) -> hit=0, valid=1, tag=0x000000.
- Write hit: edit=1, din=0x2222_2222, addr 0x08 for one cycle.
  - Read 0x08 -> dout=0x2222_2222, dirty=1.
  - Read 0x00 -> dout=0x1111_1111, hit=1, dirty=1.
- Edit miss and invalidation:
  - edit at 0xB4 -> no change (valid stays 0).
  - invalid at 0x00 -> hit=0, valid=0, dirty=0; tag remains 0, dout at 0x08 still 0x2222_2222.
